// File: rtl/load_store_unit.sv
// Single-request load/store unit bridging a core request port to a word-wide
// data memory. Sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSignExt,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        RespDone,
    output logic        RespError,
    output logic [31:0] RespReadData,
    output logic [31:0] MemAddress,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] offset;
    logic        req_error;
    logic        accept;

    logic        is_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [29:0] index;
    logic [1:0]  lane;
    logic [31:0] write_data;
    logic [31:0] read_word;

    // Extracts the addressed byte/half (little-endian) and extends it.
    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] ln, input logic sx);
        logic [31:0]        byte_shift;
        logic [31:0]        half_shift;
        logic signed [7:0]  byte_val;
        logic signed [15:0] half_val;
        byte_shift = word >> {ln, 3'b000};
        half_shift = word >> {ln[1], 4'b0000};
        byte_val   = byte_shift[7:0];
        half_val   = half_shift[15:0];
        case (sz)
            SIZE_BYTE: format_load = sx ? 32'(byte_val) : {24'h0, byte_val};
            SIZE_HALF: format_load = sx ? 32'(half_val) : {16'h0, half_val};
            default:   format_load = word;
        endcase
    endfunction

    // Replaces only the addressed lane(s) of the captured word.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] mask;
        logic [31:0] placed;
        case (sz)
            SIZE_BYTE: begin
                mask   = 32'h0000_00FF << {ln, 3'b000};
                placed = {24'h0, data[7:0]} << {ln, 3'b000};
            end
            SIZE_HALF: begin
                mask   = 32'h0000_FFFF << {ln[1], 4'b0000};
                placed = {16'h0, data[15:0]} << {ln[1], 4'b0000};
            end
            default: begin
                mask   = 32'hFFFF_FFFF;
                placed = data;
            end
        endcase
        merge_store = (word & ~mask) | (placed & mask);
    endfunction

    assign offset    = ReqAddress - BASE_ADDRESS;
    // Out-of-range check is unsigned, so addresses below the base wrap and fail too.
    assign req_error = ({2'b00, offset[31:2]} >= 32'(MEMORY_DEPTH))
                     || (ReqSize == 2'b11)
                     || ((ReqSize == SIZE_HALF) && offset[0])
                     || ((ReqSize == SIZE_WORD) && (offset[1:0] != 2'b00));
    assign accept    = ReqValid && (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                if (req_error)                              state_next = ERR;
                else if (ReqWrite && ReqSize == SIZE_WORD)  state_next = WR;
                else                                        state_next = RD;
            end
            RD:      state_next = is_write ? WR : DONE;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_write   <= ReqWrite;
            size       <= ReqSize;
            sign_ext   <= ReqSignExt;
            index      <= offset[31:2];
            lane       <= offset[1:0];
            write_data <= ReqWriteData;
        end
        if (state == RD) read_word <= MemReadData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          RespReadData <= 32'h0;
        else if (state == RD && !is_write)  RespReadData <= format_load(MemReadData, size, lane, sign_ext);
    end

    assign ReqReady     = (state == IDLE) && !reset;
    assign RespDone     = (state == DONE) || (state == ERR);
    assign RespError    = (state == ERR);
    assign MemRead      = (state == RD);
    assign MemWrite     = (state == WR);
    assign MemAddress   = (state == RD || state == WR) ? {2'b00, index} : 32'h0;
    assign MemWriteData = (state != WR)        ? 32'h0 :
                          (size == SIZE_WORD)  ? write_data :
                                                 merge_store(read_word, write_data, size, lane);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a request-level memory model predicts
// load results, written words, error flags and completion latency.
module tb_load_store_unit;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid, ReqReady, ReqWrite, ReqSignExt;
    logic [1:0]  ReqSize;
    logic [31:0] ReqAddress, ReqWriteData;
    logic        RespDone, RespError;
    logic [31:0] RespReadData, MemAddress, MemWriteData, MemReadData;
    logic        MemRead, MemWrite;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] exp_rdata;
    int          n_vec = 0;
    int          n_err = 0;

    load_store_unit #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSignExt(ReqSignExt), .ReqAddress(ReqAddress),
        .ReqWriteData(ReqWriteData), .RespDone(RespDone), .RespError(RespError),
        .RespReadData(RespReadData), .MemAddress(MemAddress), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    assign MemReadData = (MemAddress < DEPTH) ? mem[MemAddress[4:0]] : 32'h0;
    always @(posedge clk) if (MemWrite && MemAddress < DEPTH) mem[MemAddress[4:0]] <= MemWriteData;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic scramble_req();
        ReqWrite     = 1'($urandom);
        ReqSize      = 2'($urandom);
        ReqSignExt   = 1'($urandom);
        ReqAddress   = $urandom;
        ReqWriteData = $urandom;
    endtask

    // One request; garbage keeps ReqValid high with random fields while busy.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit garbage, output logic [31:0] rd_out);
        logic [31:0] offset, idx, word, val, wr_addr, wr_data;
        int          lane, nb, exp_lat, done_k, rd_cnt, wr_cnt;
        bit          err;
        offset = addr - BASE;
        idx    = offset >> 2;
        lane   = int'(offset % 4);
        err    = (idx >= DEPTH) || (sz == 2'd3) || (sz == 2'd1 && lane % 2 == 1)
              || (sz == 2'd2 && lane != 0);
        exp_lat = err ? 1 : (!w ? 2 : (sz == 2'd2 ? 2 : 3));
        wr_data = 32'h0;
        wr_addr = 32'h0;
        word    = 32'h0;
        if (!err && !w) begin
            word = ref_mem[idx];
            if (sz == 2'd0) begin
                val = (word >> (8 * lane)) % 256;
                if (sx && val >= 128) val = val + 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                val = (word >> (8 * lane)) % 65536;
                if (sx && val >= 32768) val = val + 32'hFFFF_0000;
            end else val = word;
            exp_rdata = val;
        end
        if (!err && w) begin
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1 ? 2 : 4);
            word = ref_mem[idx];
            for (int i = 0; i < nb; i++) begin
                word[8*(lane+i) +: 8] = wd[8*i +: 8];
            end
            ref_mem[idx] = word;
        end

        @(negedge clk);
        check("idle_done_low", {31'h0, RespDone}, 32'h0);
        check("idle_ready", {31'h0, ReqReady}, 32'h1);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSignExt = sx;
        ReqAddress = addr; ReqWriteData = wd;
        @(posedge clk);
        #1;
        if (garbage) scramble_req(); else ReqValid = 1'b0;

        done_k = 0; rd_cnt = 0; wr_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (MemRead) begin
                rd_cnt++;
                check("rd_addr", MemAddress, idx);
            end
            if (MemWrite) begin
                wr_cnt++;
                wr_addr = MemAddress;
                wr_data = MemWriteData;
            end
            if (!MemRead && !MemWrite) check("idle_bus", MemAddress | MemWriteData, 32'h0);
            if (RespDone) begin
                done_k = k;
                break;
            end
            check("busy_ready", {31'h0, ReqReady}, 32'h0);
            if (garbage) scramble_req();
        end
        ReqValid = 1'b0;
        check("latency", done_k, exp_lat);
        check("resp_error", {31'h0, RespError}, {31'h0, err});
        check("read_strobes", rd_cnt, (!err && (!w || sz != 2'd2)) ? 1 : 0);
        check("write_strobes", wr_cnt, (!err && w) ? 1 : 0);
        if (!err && w) begin
            check("write_addr", wr_addr, idx);
            check("write_data", wr_data, word);
        end
        check("read_data", RespReadData, exp_rdata);
        rd_out = RespReadData;
    endtask

    logic [31:0] rd;
    logic [1:0]  sz;
    logic [31:0] addr;

    initial begin
        reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqSignExt = 1'b0; ReqAddress = 32'h0; ReqWriteData = 32'h0;
        exp_rdata = 32'h0;
        #1;
        check("rst_ready", {31'h0, ReqReady}, 32'h0);
        check("rst_done", {30'h0, RespDone, RespError}, 32'h0);
        check("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_bus", MemAddress | MemWriteData | RespReadData, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom, 1'b0, rd);

        do_req(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEADBEEF, 1'b0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 1'b0, rd);
        check("word_load_const", rd, 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'h11223344, 1'b0, rd);
        do_req(1'b1, 2'd0, 1'b0, 32'h1001_0002, 32'h0000_00AA, 1'b0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, 1'b0, rd);
        check("byte_store_const", rd, 32'h11AA3344);

        do_req(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'h80FF7F01, 1'b0, rd);
        do_req(1'b0, 2'd0, 1'b1, 32'h1001_0001, 32'h0, 1'b0, rd);
        check("lb_pos_const", rd, 32'h0000007F);
        do_req(1'b0, 2'd0, 1'b1, 32'h1001_0002, 32'h0, 1'b0, rd);
        check("lb_neg_const", rd, 32'hFFFFFFFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h1001_0002, 32'h0, 1'b0, rd);
        check("lhu_const", rd, 32'h000080FF);

        do_req(1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'h0, 1'b0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h1001_0080, 32'h0, 1'b0, rd);
        do_req(1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0, 1'b0, rd);
        do_req(1'b1, 2'd0, 1'b0, 32'h1000_FFFF, 32'h55, 1'b0, rd);

        // Byte store aborted by reset while its write strobe is up.
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSignExt = 1'b0;
        ReqAddress = BASE + 32'd13; ReqWriteData = 32'h5A;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (MemWrite) break;
        end
        check("abort_wr_seen", {31'h0, MemWrite}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort_write_drop", {31'h0, MemWrite}, 32'h0);
        check("abort_no_done", {31'h0, RespDone}, 32'h0);
        check("abort_rdata_clr", RespReadData, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", {31'h0, ReqReady}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_quiet", {30'h0, RespDone, MemWrite}, 32'h0);
        end
        do_req(1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0, 1'b0, rd);

        for (int t = 0; t < 400; t++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = BASE + 32'($urandom_range(128, 140));
                default: addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            if ($urandom_range(0, 3) != 0 && sz == 2'd2) addr[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0 && sz == 2'd1) addr[0] = 1'b0;
            do_req(1'($urandom), sz, 1'($urandom), addr, $urandom, 1'($urandom), rd);
        end

        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 2'd2, 1'b0, BASE + 32'(4 * i), 32'h0, 1'b0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
